// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter_pkg
// Purpose : Shared constants and state encoding for the main-RAM arbiter.
//           RAM_ADDR_W / RAM_DATA_W describe the 1024x8 main RAM.
// Revision: 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ISSUE  = 2'd1,
    ARB_RDWAIT = 2'd2
  } arb_state_t;

endpackage : ram_arbiter_pkg
`default_nettype wire

// File: rtl/ram_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker
// Purpose : Combinational round-robin priority encoder. Returns the first
//           requester with req=1 searching upward from rr_ptr, modulo NUM_REQ.
// Ports   : req     in  NUM_REQ  request vector
//           rr_ptr  in  IDX_W    search start index (always < NUM_REQ)
//           winner  out IDX_W    selected index (0 when none)
//           any_req out 1        at least one request present
// Revision: 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_req && req[w_idx]) begin
        winner  = w_idx;
        any_req = 1'b1;
      end
    end
  end

endmodule : rr_picker
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter
// Purpose : Shares main RAM between NUM_REQ requesters. Round-robin grant,
//           one RAM access per grant, optional lock for back-to-back bursts
//           capped at LOCK_MAX consecutive grants.
// Ports   : clock/reset_n      clock, async active-low reset
//           req/lock/we        per-requester request, lock, write flag
//           addr/wdata         packed per-requester address / write data
//           gnt                one-hot access-issued pulse
//           rvalid/rdata       one-hot read-return pulse and shared data
//           ram_en/ram_write/ram_addr/ram_wdata/ram_rdata  RAM interface
//           busy               access or read return in progress
// Revision: 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int LOCK_MAX = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ram_en,
  output logic                      ram_write,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic                      busy
);

  localparam int C_IDX_W = $clog2(NUM_REQ);
  localparam int C_CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [C_CNT_W-1:0] C_LOCK_LAST = C_CNT_W'(LOCK_MAX - 1);

  arb_state_t           r_state, w_state_nxt;
  logic [C_IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [C_IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [C_CNT_W-1:0]   r_lock_cnt, w_lock_cnt_nxt;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]   r_rvalid, w_rvalid_nxt;
  logic [DATA_W-1:0]    r_rdata, w_rdata_nxt;
  logic                 r_ram_en, w_ram_en_nxt;
  logic                 r_ram_write, w_ram_write_nxt;
  logic [ADDR_W-1:0]    r_ram_addr, w_ram_addr_nxt;
  logic [DATA_W-1:0]    r_ram_wdata, w_ram_wdata_nxt;

  logic [C_IDX_W-1:0]   w_pick;
  logic                 w_any;
  logic [C_IDX_W-1:0]   w_win;
  logic                 w_decide;
  logic                 w_chain;
  logic [NUM_REQ-1:0]   w_owner_oh;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (C_IDX_W)
  ) u_picker (
    .req     (req),
    .rr_ptr  (r_rr_ptr),
    .winner  (w_pick),
    .any_req (w_any)
  );

  assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_lock_cnt_nxt  = r_lock_cnt;
    w_gnt_nxt       = '0;
    w_rvalid_nxt    = '0;
    w_rdata_nxt     = r_rdata;
    w_ram_en_nxt    = 1'b0;
    w_ram_write_nxt = 1'b0;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_win           = w_pick;
    w_decide        = 1'b0;
    w_chain         = 1'b0;

    case (r_state)
      ARB_IDLE:   w_decide = 1'b1;
      // A read needs a bubble so its data can be captured before the next access.
      ARB_ISSUE: begin
        if (r_ram_write) w_decide = 1'b1;
        else             w_state_nxt = ARB_RDWAIT;
      end
      ARB_RDWAIT: begin
        w_decide     = 1'b1;
        w_rvalid_nxt = w_owner_oh;
        w_rdata_nxt  = ram_rdata;
      end
      default:    w_state_nxt = ARB_IDLE;
    endcase

    if (w_decide) begin
      // Lock only matters when someone else is waiting; a lone requester wins
      // through round-robin anyway and its burst count restarts.
      w_chain = (r_state != ARB_IDLE) && lock[r_owner] && req[r_owner] &&
                (r_lock_cnt < C_LOCK_LAST) && (|(req & ~w_owner_oh));
      if (w_chain) begin
        w_win          = r_owner;
        w_lock_cnt_nxt = r_lock_cnt + C_CNT_W'(1);
      end else begin
        w_lock_cnt_nxt = '0;
      end

      if (w_chain || w_any) begin
        w_state_nxt     = ARB_ISSUE;
        w_owner_nxt     = w_win;
        w_rr_ptr_nxt    = (w_win == C_IDX_W'(NUM_REQ - 1)) ? '0 : w_win + C_IDX_W'(1);
        w_gnt_nxt       = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
        w_ram_en_nxt    = 1'b1;
        w_ram_write_nxt = we[w_win];
        w_ram_addr_nxt  = ADDR_W'(addr >> (int'(w_win) * ADDR_W));
        w_ram_wdata_nxt = DATA_W'(wdata >> (int'(w_win) * DATA_W));
      end else begin
        w_state_nxt     = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ARB_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_lock_cnt  <= '0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_ram_en    <= 1'b0;
      r_ram_write <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rvalid    <= w_rvalid_nxt;
      r_rdata     <= w_rdata_nxt;
      r_ram_en    <= w_ram_en_nxt;
      r_ram_write <= w_ram_write_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign ram_en    = r_ram_en;
  assign ram_write = r_ram_write;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign busy      = (r_state != ARB_IDLE) | (|r_rvalid);

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_arbiter
// Purpose : Self-checking bench for ram_arbiter (3 requesters, LOCK_MAX=4).
//           Directed vector table, a reset-during-read sequence, then random
//           traffic against a behavioural model with a shadow memory.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LM = 4;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [N-1:0]  rvalid;
    logic [DW-1:0] rdata;
    logic          en;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          busy;
  } outs_t;

  typedef struct {
    logic [N-1:0] rq;
    logic [N-1:0] lk;
    logic [N-1:0] w;
    outs_t        e;
  } vec_t;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req, lock, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            ram_en, ram_write;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  // Synchronous main RAM: read data appears the cycle after a read enable.
  logic [DW-1:0] mem [0:1023];
  logic          mem_clear;
  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      ram_rdata <= '0;
    end else if (ram_en) begin
      if (ram_write) mem[ram_addr] <= ram_wdata;
      else           ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input outs_t e);
    chk({tag, ".gnt"},    32'(gnt),       32'(e.gnt));
    chk({tag, ".rvalid"}, 32'(rvalid),    32'(e.rvalid));
    chk({tag, ".rdata"},  32'(rdata),     32'(e.rdata));
    chk({tag, ".ram_en"}, 32'(ram_en),    32'(e.en));
    chk({tag, ".ram_wr"}, 32'(ram_write), 32'(e.wr));
    chk({tag, ".addr"},   32'(ram_addr),  32'(e.a));
    chk({tag, ".wdata"},  32'(ram_wdata), 32'(e.d));
    chk({tag, ".busy"},   32'(busy),      32'(e.busy));
  endtask

  function automatic vec_t v(input logic [2:0] rq, input logic [2:0] lk, input logic [2:0] w,
                             input logic [2:0] gn, input logic [2:0] rv, input logic [7:0] rd,
                             input logic en, input logic wr, input logic [9:0] a,
                             input logic [7:0] d, input logic bz);
    vec_t r;
    r.rq = rq; r.lk = lk; r.w = w;
    r.e.gnt = gn; r.e.rvalid = rv; r.e.rdata = rd; r.e.en = en; r.e.wr = wr;
    r.e.a = a; r.e.d = d; r.e.busy = bz;
    return r;
  endfunction

  function automatic logic bit_at(input logic [N-1:0] vec, input int i);
    logic [N-1:0] t;
    t = vec >> i;
    return t[0];
  endfunction

  // ---------------- behavioural reference model ----------------
  int            m_ptr, m_last, m_run, m_rd_stage, m_rd_who;
  logic [DW-1:0] m_rd_data, m_rdata;
  logic [DW-1:0] shadow [0:1023];
  outs_t         m_exp;

  task automatic model_reset();
    m_ptr = 0; m_last = -1; m_run = 0; m_rd_stage = 0; m_rd_who = 0;
    m_rd_data = '0; m_rdata = '0;
    m_exp.gnt = '0; m_exp.rvalid = '0; m_exp.rdata = '0; m_exp.en = 1'b0;
    m_exp.wr = 1'b0; m_exp.a = '0; m_exp.d = '0; m_exp.busy = 1'b0;
    for (int i = 0; i < 1024; i++) shadow[i] = '0;
  endtask

  // One clock edge with the current inputs; m_exp becomes the outputs for the following cycle.
  task automatic model_step();
    int  w;
    bit  others;
    bit  chain;
    m_exp.gnt = '0; m_exp.rvalid = '0; m_exp.en = 1'b0; m_exp.wr = 1'b0;
    if (m_rd_stage == 2) begin
      m_exp.rvalid = N'(1) << m_rd_who;
      m_rdata = m_rd_data;
      m_rd_stage = 0;
    end
    m_exp.rdata = m_rdata;
    if (m_rd_stage == 1) begin
      m_rd_stage = 2;
      m_exp.busy = 1'b1;
      return;
    end
    others = 0;
    for (int j = 0; j < N; j++) if (j != m_last && bit_at(req, j)) others = 1;
    chain = (m_last >= 0) && bit_at(lock, m_last) && bit_at(req, m_last) &&
            (m_run < LM - 1) && others;
    w = -1;
    if (chain) begin
      w = m_last;
      m_run++;
    end else begin
      m_run = 0;
      for (int k = 0; k < N; k++) if (w < 0 && bit_at(req, (m_ptr + k) % N)) w = (m_ptr + k) % N;
    end
    if (w >= 0) begin
      m_exp.gnt = N'(1) << w;
      m_exp.en  = 1'b1;
      m_exp.wr  = bit_at(we, w);
      m_exp.a   = AW'(addr >> (w * AW));
      m_exp.d   = DW'(wdata >> (w * DW));
      m_ptr     = (w + 1) % N;
      if (m_exp.wr) shadow[m_exp.a] = m_exp.d;
      else begin
        m_rd_stage = 1; m_rd_who = w; m_rd_data = shadow[m_exp.a];
      end
      m_last = w;
    end else begin
      m_last = -1;
    end
    m_exp.busy = (w >= 0) || (m_exp.rvalid != '0);
  endtask

  vec_t  vt [24];
  outs_t z;

  initial begin
    z.gnt = '0; z.rvalid = '0; z.rdata = '0; z.en = 1'b0; z.wr = 1'b0;
    z.a = '0; z.d = '0; z.busy = 1'b0;

    // Directed vectors: inputs applied before an edge, outputs checked in the next cycle.
    vt[0]  = v(3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 8'h00, 1, 1, 10'h005, 8'hA5, 1);
    vt[1]  = v(3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 8'h00, 1, 0, 10'h005, 8'h3C, 1);
    vt[2]  = v(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00, 0, 0, 10'h005, 8'h3C, 1);
    vt[3]  = v(3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 8'hA5, 0, 0, 10'h005, 8'h3C, 1);
    for (int i = 4; i < 8; i++)
      vt[i] = (i % 2 == 0) ? v(3'b011, 3'b000, 3'b011, 3'b001, 3'b000, 8'hA5, 1, 1, 10'h005, 8'hA5, 1)
                           : v(3'b011, 3'b000, 3'b011, 3'b010, 3'b000, 8'hA5, 1, 1, 10'h005, 8'h3C, 1);
    for (int i = 8; i < 17; i++)
      vt[i] = (i == 12) ? v(3'b011, 3'b001, 3'b011, 3'b010, 3'b000, 8'hA5, 1, 1, 10'h005, 8'h3C, 1)
                        : v(3'b011, 3'b001, 3'b011, 3'b001, 3'b000, 8'hA5, 1, 1, 10'h005, 8'hA5, 1);
    vt[17] = v(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'hA5, 0, 0, 10'h005, 8'hA5, 0);
    vt[18] = v(3'b010, 3'b000, 3'b010, 3'b010, 3'b000, 8'hA5, 1, 1, 10'h005, 8'h3C, 1);
    vt[19] = v(3'b101, 3'b000, 3'b101, 3'b100, 3'b000, 8'hA5, 1, 1, 10'h0F0, 8'h5A, 1);
    vt[20] = v(3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 8'hA5, 1, 1, 10'h005, 8'hA5, 1);
    vt[21] = v(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'hA5, 0, 0, 10'h005, 8'hA5, 0);
    vt[22] = v(3'b011, 3'b000, 3'b011, 3'b010, 3'b000, 8'hA5, 1, 1, 10'h005, 8'h3C, 1);
    vt[23] = v(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'hA5, 0, 0, 10'h005, 8'h3C, 0);

    reset_n = 1'b0; mem_clear = 1'b1;
    req = '0; lock = '0; we = '0;
    addr  = {10'h0F0, 10'h005, 10'h005};
    wdata = {8'h5A, 8'h3C, 8'hA5};
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_outs("reset", z);
    reset_n = 1'b1; mem_clear = 1'b0;

    for (int i = 0; i < 24; i++) begin
      req = vt[i].rq; lock = vt[i].lk; we = vt[i].w;
      @(posedge clock);
      @(negedge clock);
      chk_outs($sformatf("vec%0d", i), vt[i].e);
    end

    // Reset while a read is waiting for its data.
    req = 3'b100; we = 3'b000;
    @(posedge clock); @(negedge clock);
    chk("rdrst.gnt",  32'(gnt),      32'(3'b100));
    chk("rdrst.addr", 32'(ram_addr), 32'(10'h0F0));
    req = '0;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk_outs("rst_async", z);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); @(negedge clock);
      chk_outs($sformatf("post_rst%0d", i), z);
    end
    req = 3'b011; we = 3'b011;
    @(posedge clock); @(negedge clock);
    chk("post_rst.gnt",  32'(gnt),      32'(3'b001));
    chk("post_rst.en",   32'(ram_en),   32'(1'b1));
    chk("post_rst.addr", 32'(ram_addr), 32'(10'h005));
    req = '0; we = '0;
    @(posedge clock); @(negedge clock);
    chk("post_rst.idle", 32'({gnt, ram_en}), 32'(0));

    // Random traffic against the reference model.
    reset_n = 1'b0; mem_clear = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1; mem_clear = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      chk_outs($sformatf("rnd%0d", c), m_exp);
      for (int i = 0; i < N; i++) begin
        req[i]  = ($urandom_range(0, 99) < 65);
        lock[i] = ($urandom_range(0, 99) < 40);
        we[i]   = ($urandom_range(0, 99) < 50);
      end
      for (int i = 0; i < N; i++) begin
        addr  = (addr  & ~({{(N*AW-AW){1'b0}}, {AW{1'b1}}} << (i * AW))) |
                ((N*AW)'($urandom_range(0, 15)) << (i * AW));
        wdata = (wdata & ~({{(N*DW-DW){1'b0}}, {DW{1'b1}}} << (i * DW))) |
                ((N*DW)'($urandom_range(0, 255)) << (i * DW));
      end
      model_step();
      @(posedge clock);
      @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ram_arbiter
`default_nettype wire
